// File: rtl/display_pkg.sv
// Shared definitions for the HEX display path: converter FSM states,
// default geometry and the BCD digit used when a value saturates.
package display_pkg;

  localparam int unsigned DEF_BIN_W  = 20;
  localparam int unsigned DEF_DIGITS = 6;

  localparam logic [3:0] BCD_NINE = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit correction cell for shift-and-add-3: digits of 5 or more
// get +3 so the following left shift carries correctly into the next digit.
module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = (din >= 4'd5) ? din + 4'd3 : din;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter feeding the HEX seven-segment decoders.
// Produces packed BCD digits, a leading-zero blank mask and a saturation flag.
module bin_to_bcd_seq
  import display_pkg::*;
#(
  parameter int unsigned BIN_W  = DEF_BIN_W,
  parameter int unsigned DIGITS = DEF_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank
);

  localparam int unsigned SW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(BIN_W + 1);
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  state_t            state, state_next;
  logic [BIN_W-1:0]  shreg;
  logic [SW-1:0]     scratch;
  logic [SW-1:0]     adj;
  logic              ovf;
  logic [CW-1:0]     cnt;
  logic [SW-1:0]     result;
  logic [DIGITS-1:0] blank_next;
  logic              zero_above;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (scratch[4*g +: 4]),
      .dout (adj[4*g +: 4])
    );
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt == CW'(1)) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
    end
  end

  // Saturated value drives both bcd and blank, so an overflow never blanks.
  always_comb begin
    result     = ovf ? {DIGITS{BCD_NINE}} : scratch;
    blank_next = '0;
    zero_above = 1'b1;
    for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
      zero_above    = zero_above & (result[4*i +: 4] == 4'd0);
      blank_next[i] = zero_above;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      scratch  <= '0;
      ovf      <= 1'b0;
      cnt      <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
      bcd      <= '0;
      blank    <= BLANK_RST;
    end else begin
      done <= (state == FINISH);
      case (state)
        IDLE: begin
          if (start) begin
            shreg   <= bin;
            scratch <= '0;
            ovf     <= 1'b0;
            cnt     <= CW'(BIN_W);
          end
        end
        SHIFT: begin
          // Bit shifted out of the top digit is sticky: the value did not fit.
          ovf     <= ovf | adj[SW-1];
          scratch <= {adj[SW-2:0], shreg[BIN_W-1]};
          shreg   <= shreg << 1;
          cnt     <= cnt - CW'(1);
        end
        FINISH: begin
          bcd      <= result;
          overflow <= ovf;
          blank    <= blank_next;
        end
        default: ;
      endcase
    end
  end

endmodule
